// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared FSM state encoding and default requester count for cache_req_arbiter
package cache_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick (req_i, last_grant_i -> any_o, winner_o), priority starts at last_grant_i+1
module rr_priority_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_grant_i,
  output logic                any_o,
  output logic [ID_WIDTH-1:0] winner_o
);
  assign any_o = |req_i;
  always_comb begin
    winner_o = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_i[(int'(last_grant_i) + k) % NUM_REQ]) winner_o = ID_WIDTH'((int'(last_grant_i) + k) % NUM_REQ);
  end
endmodule

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin arbiter serialising NUM_REQ requesters (req_*/resp_*) onto one cache port (cache_*), reporting busy/grant_id
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          cache_req_valid,
  input  logic                          cache_req_ready,
  output logic                          cache_write_en,
  output logic [ADDRESS_WIDTH-1:0]      cache_mem_add,
  output logic [DATA_WIDTH-1:0]         cache_data_in,
  input  logic                          cache_resp_valid,
  input  logic [DATA_WIDTH-1:0]         cache_data_out,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id
);
  state_e state_q, state_d;
  logic [ID_WIDTH-1:0] last_q, last_d, id_q, id_d, win;
  logic we_q, we_d, any, accept;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] resp_q, resp_d;
  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
    .req_i(req_valid),
    .last_grant_i(last_q),
    .any_o(any),
    .winner_o(win)
  );
  assign accept = (state_q == ST_IDLE) && any && !reset;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    resp_d = '0;
    rdata_d = '0;
    req_ready = '0;
    if (accept) begin
      req_ready[win] = 1'b1;
      state_d = ST_ISSUE;
      id_d = win;
      we_d = req_write[win];
      addr_d = req_addr[win*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    end
    if (state_q == ST_ISSUE && cache_req_ready) state_d = ST_WAIT;
    // WAIT stays put for the resp_valid cycle so the next accept lands one cycle later
    if (state_q == ST_WAIT) begin
      if (|resp_q) begin
        state_d = ST_IDLE;
        last_d = id_q;
      end else if (cache_resp_valid) begin
        resp_d = NUM_REQ'(1) << id_q;
        rdata_d = we_q ? '0 : cache_data_out;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q <= ID_WIDTH'(NUM_REQ - 1);
      id_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      resp_q <= resp_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign grant_id = busy ? id_q : '0;
  assign cache_req_valid = state_q == ST_ISSUE;
  assign cache_write_en = we_q;
  assign cache_mem_add = addr_q;
  assign cache_data_in = wdata_q;
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed scenarios plus randomized run against a transaction-level model of cache_req_arbiter
module tb_cache_req_arbiter;
  localparam int N = 4, AW = 32, DW = 32;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_valid, req_write, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata, cache_data_out, cache_data_in;
  logic cache_req_valid, cache_req_ready, cache_write_en, cache_resp_valid, busy;
  logic [AW-1:0] cache_mem_add;
  logic [1:0] grant_id;
  int vectors = 0, miscompares = 0;
  int gq[$], gc[$];
  always #5 clk = ~clk;
  cache_req_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_write_en(cache_write_en), .cache_mem_add(cache_mem_add), .cache_data_in(cache_data_in),
    .cache_resp_valid(cache_resp_valid), .cache_data_out(cache_data_out),
    .busy(busy), .grant_id(grant_id)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    cache_req_ready = 1'b0;
    cache_resp_valid = 1'b0;
    cache_data_out = '0;
  endtask
  task automatic do_reset;
    quiet();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic collect(input int n);
    gq.delete();
    gc.delete();
    for (int c = 0; c < 60 && gq.size() < n; c++) begin
      #1;
      if (req_ready != 0) begin
        gq.push_back($clog2(req_ready));
        gc.push_back(c);
      end
      step();
    end
  endtask
  task automatic test_reset;
    quiet();
    req_valid = 4'b1111;
    reset = 1'b1;
    step();
    step();
    vectors++;
    if ({busy, grant_id, cache_req_valid, resp_valid, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got busy=%b gid=%0d crv=%b resp=%b ready=%b want all 0", busy, grant_id, cache_req_valid, resp_valid, req_ready);
    end
    vectors++;
    if ({cache_write_en, cache_mem_add, cache_data_in, resp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got we=%b add=%h din=%h rdata=%h want 0", cache_write_en, cache_mem_add, cache_data_in, resp_rdata);
    end
    reset = 1'b0;
    quiet();
  endtask
  task automatic test_single_read;
    do_reset();
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 32'h40;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rd_accept got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    cache_req_ready = 1'b1;
    #1;
    vectors++;
    if ({cache_req_valid, cache_write_en, cache_mem_add, busy, grant_id} !== {1'b1, 1'b0, 32'h40, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL rd_issue got crv=%b we=%b add=%h busy=%b gid=%0d want 1 0 40 1 0", cache_req_valid, cache_write_en, cache_mem_add, busy, grant_id);
    end
    step();
    cache_req_ready = 1'b0;
    #1;
    vectors++;
    if (cache_req_valid !== 1'b0) begin miscompares++; $display("FAIL rd_wait_crv got %b want 0", cache_req_valid); end
    step();
    cache_resp_valid = 1'b1;
    cache_data_out = 32'hDEADBEEF;
    step();
    cache_resp_valid = 1'b0;
    cache_data_out = '0;
    #1;
    vectors++;
    if ({resp_valid, resp_rdata} !== {4'b0001, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL rd_resp got %b/%h want 0001/deadbeef", resp_valid, resp_rdata);
    end
    step();
    vectors++;
    if ({resp_valid, busy} !== 5'b0) begin miscompares++; $display("FAIL rd_done got resp=%b busy=%b want 0 0", resp_valid, busy); end
  endtask
  task automatic test_round_robin;
    do_reset();
    req_valid = 4'b1111;
    cache_req_ready = 1'b1;
    cache_resp_valid = 1'b1;
    collect(5);
    vectors++;
    if (gq.size() != 5) begin miscompares++; $display("FAIL rr_count got %0d want 5", gq.size()); end
    for (int i = 0; i < gq.size(); i++) begin
      vectors++;
      if (gq[i] != i % 4) begin miscompares++; $display("FAIL rr_order[%0d] got %0d want %0d", i, gq[i], i % 4); end
    end
  endtask
  task automatic test_back_to_back;
    do_reset();
    req_valid = 4'b0100;
    cache_req_ready = 1'b1;
    cache_resp_valid = 1'b1;
    collect(3);
    vectors++;
    if (gq.size() != 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", gq.size()); end
    for (int i = 0; i + 1 < gq.size(); i++) begin
      vectors++;
      if (gq[i + 1] != 2 || gc[i + 1] - gc[i] != 4) begin
        miscompares++;
        $display("FAIL b2b_gap[%0d] got id=%0d gap=%0d want id=2 gap=4", i, gq[i + 1], gc[i + 1] - gc[i]);
      end
    end
  endtask
  task automatic test_stall;
    do_reset();
    req_valid = 4'b1111;
    req_addr[0 +: AW] = 32'h1234;
    req_wdata[0 +: DW] = 32'hA5A5_5A5A;
    step();
    for (int i = 0; i < 5; i++) begin
      req_addr = {4{$urandom}};
      req_wdata = {4{$urandom}};
      #1;
      vectors++;
      if ({cache_req_valid, cache_mem_add, cache_data_in, req_ready} !== {1'b1, 32'h1234, 32'hA5A5_5A5A, 4'b0}) begin
        miscompares++;
        $display("FAIL stall[%0d] got crv=%b add=%h din=%h ready=%b want 1 1234 a5a55a5a 0000", i, cache_req_valid, cache_mem_add, cache_data_in, req_ready);
      end
      step();
    end
    quiet();
    cache_req_ready = 1'b1;
    step();
    cache_req_ready = 1'b0;
    cache_resp_valid = 1'b1;
    step();
    cache_resp_valid = 1'b0;
    #1;
    vectors++;
    if (resp_valid !== 4'b0001) begin miscompares++; $display("FAIL stall_resp got %b want 0001", resp_valid); end
    step();
  endtask
  task automatic test_write;
    do_reset();
    req_valid = 4'b0100;
    req_write = 4'b0100;
    req_addr[2*AW +: AW] = 32'h80;
    req_wdata[2*DW +: DW] = 32'h12345678;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL wr_accept got %b want 0100", req_ready); end
    step();
    quiet();
    cache_req_ready = 1'b1;
    #1;
    vectors++;
    if ({cache_write_en, cache_data_in, cache_mem_add, grant_id} !== {1'b1, 32'h12345678, 32'h80, 2'd2}) begin
      miscompares++;
      $display("FAIL wr_issue got we=%b din=%h add=%h gid=%0d want 1 12345678 80 2", cache_write_en, cache_data_in, cache_mem_add, grant_id);
    end
    step();
    cache_req_ready = 1'b0;
    cache_resp_valid = 1'b1;
    cache_data_out = 32'hFFFF_FFFF;
    step();
    cache_resp_valid = 1'b0;
    #1;
    vectors++;
    if ({resp_valid, resp_rdata} !== {4'b0100, 32'h0}) begin
      miscompares++;
      $display("FAIL wr_resp got %b/%h want 0100/00000000", resp_valid, resp_rdata);
    end
    step();
  endtask
  task automatic test_reset_in_wait;
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    cache_req_ready = 1'b1;
    step();
    cache_req_ready = 1'b0;
    #1;
    vectors++;
    if ({busy, cache_req_valid} !== 2'b10) begin miscompares++; $display("FAIL rw_in_wait got busy=%b crv=%b want 1 0", busy, cache_req_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cache_resp_valid = 1'b1;
    cache_data_out = 32'hCAFE_F00D;
    step();
    cache_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({resp_valid, busy} !== 5'b0) begin miscompares++; $display("FAIL rw_after[%0d] got resp=%b busy=%b want 0 0", i, resp_valid, busy); end
      step();
    end
  endtask
  task automatic test_resp_in_issue;
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    cache_resp_valid = 1'b1;
    cache_data_out = 32'h111;
    step();
    cache_resp_valid = 1'b0;
    #1;
    vectors++;
    if ({cache_req_valid, resp_valid} !== 5'b10000) begin miscompares++; $display("FAIL ri_issue got crv=%b resp=%b want 1 0000", cache_req_valid, resp_valid); end
    cache_req_ready = 1'b1;
    step();
    cache_req_ready = 1'b0;
    step();
    #1;
    vectors++;
    if ({cache_req_valid, resp_valid} !== 5'b0) begin miscompares++; $display("FAIL ri_wait got crv=%b resp=%b want 0 0000", cache_req_valid, resp_valid); end
    cache_resp_valid = 1'b1;
    cache_data_out = 32'h222;
    step();
    cache_resp_valid = 1'b0;
    #1;
    vectors++;
    if ({resp_valid, resp_rdata} !== {4'b0001, 32'h222}) begin
      miscompares++;
      $display("FAIL ri_resp got %b/%h want 0001/00000222", resp_valid, resp_rdata);
    end
    step();
  endtask
  task automatic test_random;
    int m_last, m_owner, m_phase, w;
    bit m_pend, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [N-1:0] exp_ready, exp_resp;
    logic [108:0] exp_v, got_v;
    do_reset();
    m_last = N - 1;
    m_owner = -1;
    m_phase = 0;
    m_pend = 0;
    m_we = 0;
    m_addr = '0;
    m_wd = '0;
    m_rd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = $urandom_range(0, 59) == 0;
      req_valid = 4'($urandom);
      req_write = 4'($urandom);
      req_addr = {$urandom, $urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      cache_req_ready = $urandom_range(0, 1) == 1;
      cache_resp_valid = $urandom_range(0, 2) == 0;
      cache_data_out = $urandom;
      w = -1;
      for (int k = N; k >= 1; k--) if (req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      exp_ready = (!reset && m_owner < 0 && w >= 0) ? 4'(1) << w : 4'b0;
      exp_resp = m_pend ? 4'(1) << m_owner : 4'b0;
      exp_v = {exp_ready, exp_resp, m_pend ? m_rd : 32'h0, m_phase == 1, m_we, m_addr, m_wd, m_owner >= 0, m_owner >= 0 ? 2'(m_owner) : 2'd0};
      #1;
      got_v = {req_ready, resp_valid, resp_rdata, cache_req_valid, cache_write_en, cache_mem_add, cache_data_in, busy, grant_id};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL rand[%0d] got %h want %h", cyc, got_v, exp_v);
      end
      if (reset) begin
        m_last = N - 1; m_owner = -1; m_phase = 0; m_pend = 0; m_we = 0; m_addr = '0; m_wd = '0;
      end else if (m_owner < 0) begin
        if (w >= 0) begin
          m_owner = w; m_phase = 1; m_we = req_write[w]; m_addr = req_addr[w*AW +: AW]; m_wd = req_wdata[w*DW +: DW];
        end
      end else if (m_phase == 1) begin
        if (cache_req_ready) m_phase = 2;
      end else if (m_pend) begin
        m_last = m_owner; m_owner = -1; m_phase = 0; m_pend = 0;
      end else if (cache_resp_valid) begin
        m_pend = 1; m_rd = m_we ? 32'h0 : cache_data_out;
      end
      step();
    end
    reset = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
  initial begin
    quiet();
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_write();
    test_reset_in_wait();
    test_resp_in_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
